// File: rtl/mainfsm.sv
// Multi-cycle control FSM for the ARM-subset processor: Moore decode of state into mux selects and raw write enables.
// Optional MAINFSM_MEMWAIT_EN adds MemReady to stall FETCH, MEMREAD and MEMWRITE on slow memory.
module mainfsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
`ifdef MAINFSM_MEMWAIT_EN
    input  logic               MemReady,
`endif
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               IsLong,
    output logic               IRWrite,
    output logic               AdrSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic               NextPC,
    output logic               RegW,
    output logic               RegWHi,
    output logic               MemW,
    output logic               Branch,
    output logic               ALUOp,
    output logic [STATE_W-1:0] State
);

    typedef enum logic [STATE_W-1:0] {
        FETCH    = STATE_W'(0),
        DECODE   = STATE_W'(1),
        MEMADR   = STATE_W'(2),
        MEMREAD  = STATE_W'(3),
        MEMWB    = STATE_W'(4),
        MEMWRITE = STATE_W'(5),
        EXECUTER = STATE_W'(6),
        EXECUTEI = STATE_W'(7),
        ALUWB    = STATE_W'(8),
        BRANCH   = STATE_W'(9),
        ALUWBHI  = STATE_W'(10)
    } state_t;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] dec_state;
    logic               mem_ready;
    logic               unused_funct;

`ifdef MAINFSM_MEMWAIT_EN
    assign mem_ready = MemReady;
`else
    assign mem_ready = 1'b1;
`endif

    assign unused_funct = ^Funct[4:1];
    assign State        = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:    if (mem_ready) state <= DECODE;
                DECODE: begin
                    case (Op)
                        2'b00:   state <= Funct[5] ? EXECUTEI : EXECUTER;
                        2'b01:   state <= MEMADR;
                        2'b10:   state <= BRANCH;
                        default: state <= FETCH;
                    endcase
                end
                MEMADR:   state <= Funct[0] ? MEMREAD : MEMWRITE;
                MEMREAD:  if (mem_ready) state <= MEMWB;
                MEMWB:    state <= FETCH;
                MEMWRITE: if (mem_ready) state <= FETCH;
                EXECUTER: state <= ALUWB;
                EXECUTEI: state <= ALUWB;
                ALUWB:    state <= IsLong ? ALUWBHI : FETCH;
                default:  state <= FETCH;
            endcase
        end
    end

    // During reset the muxes present their FETCH selects; enables are cleared below.
    assign dec_state = reset ? FETCH : state;

    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        RegWHi    = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        ALUOp     = 1'b0;
        case (dec_state)
            FETCH: begin
                IRWrite   = mem_ready;
                NextPC    = mem_ready;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR:   ALUSrcB = 2'b01;
            MEMREAD:  AdrSrc  = 1'b1;
            MEMWRITE: begin
                AdrSrc = 1'b1;
                MemW   = mem_ready;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            EXECUTER: ALUOp = 1'b1;
            EXECUTEI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
            end
            ALUWB:    RegW   = 1'b1;
            ALUWBHI:  RegWHi = 1'b1;
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            IRWrite = 1'b0;
            NextPC  = 1'b0;
            RegW    = 1'b0;
            RegWHi  = 1'b0;
            MemW    = 1'b0;
            Branch  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mainfsm.sv
// Self-checking bench for mainfsm: instruction-level reference model of state sequences and per-state outputs.
// Build with MAINFSM_MEMWAIT_EN defined to also exercise the memory-wait handshake.
module tb_mainfsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       IsLong;
    logic       IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, RegWHi, MemW, Branch, ALUOp;
    logic [1:0] ALUSrcB, ResultSrc;
    logic [3:0] State;
`ifdef MAINFSM_MEMWAIT_EN
    logic       MemReady = 1'b1;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    mainfsm #(.STATE_W(4)) dut (
        .clk(clk),
        .reset(reset),
`ifdef MAINFSM_MEMWAIT_EN
        .MemReady(MemReady),
`endif
        .Op(Op),
        .Funct(Funct),
        .IsLong(IsLong),
        .IRWrite(IRWrite),
        .AdrSrc(AdrSrc),
        .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc),
        .NextPC(NextPC),
        .RegW(RegW),
        .RegWHi(RegWHi),
        .MemW(MemW),
        .Branch(Branch),
        .ALUOp(ALUOp),
        .State(State)
    );

    // Expected state walk of one instruction, from FETCH up to (not including) the next FETCH.
    function automatic void build_seq(input logic [1:0] op, input logic [5:0] f, input logic il);
        exp_q.delete();
        exp_q.push_back(0);
        exp_q.push_back(1);
        if (op == 2'b01) begin
            exp_q.push_back(2);
            if (f[0]) begin
                exp_q.push_back(3);
                exp_q.push_back(4);
            end else begin
                exp_q.push_back(5);
            end
        end else if (op == 2'b00) begin
            exp_q.push_back(f[5] ? 7 : 6);
            exp_q.push_back(8);
            if (il) exp_q.push_back(10);
        end else if (op == 2'b10) begin
            exp_q.push_back(9);
        end
    endfunction

    // Packed {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,NextPC,RegW,RegWHi,MemW,Branch,ALUOp}
    function automatic logic [12:0] exp_out(input int s, input logic rst, input logic mr);
        logic ir, adr, sa, np, rw, rwh, mw, br, aop;
        logic [1:0] sb, rs;
        int st;
        st = rst ? 0 : s;
        {ir, adr, sa, np, rw, rwh, mw, br, aop} = '0;
        sb = 2'b00;
        rs = 2'b00;
        case (st)
            0:  begin ir = 1; np = 1; sa = 1; sb = 2'b10; rs = 2'b10; end
            1:  begin sa = 1; sb = 2'b10; rs = 2'b10; end
            2:  sb = 2'b01;
            3:  adr = 1;
            4:  begin rs = 2'b01; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  aop = 1;
            7:  begin sb = 2'b01; aop = 1; end
            8:  rw = 1;
            9:  begin sb = 2'b01; rs = 2'b10; br = 1; end
            10: rwh = 1;
            default: ;
        endcase
        if (rst) {ir, np, rw, rwh, mw, br} = '0;
        if (!mr) {ir, np, mw} = '0;
        return {ir, adr, sa, sb, rs, np, rw, rwh, mw, br, aop};
    endfunction

    function automatic logic [12:0] obs();
        return {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, RegWHi, MemW, Branch, ALUOp};
    endfunction

    // Instruction fields only at the states that branch on them; random junk everywhere else.
    task automatic drive_inputs(input int s, input logic [1:0] op, input logic [5:0] f, input logic il);
        Op     = 2'($urandom);
        Funct  = 6'($urandom);
        IsLong = 1'($urandom);
        if (s == 1) begin Op = op; Funct = f; end
        if (s == 2) Funct = f;
        if (s == 8) IsLong = il;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_inputs(0, 2'b00, 6'd0, 1'b0);
        @(negedge clk);
        #1;
        n_checks++;
        if (obs() !== exp_out(0, 1'b1, 1'b1))
            $display("FAIL reset_outputs: got %b expected %b", obs(), exp_out(0, 1'b1, 1'b1));
        @(negedge clk);
        #1;
        n_checks++;
        if (State !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d expected 0", State);
        end
        n_checks++;
        if (obs() !== exp_out(0, 1'b1, 1'b1)) begin
            n_fail++;
            $display("FAIL reset_outputs_held: got %b expected %b", obs(), exp_out(0, 1'b1, 1'b1));
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (obs() !== exp_out(0, 1'b0, 1'b1)) begin
            n_fail++;
            $display("FAIL fetch_after_reset: got %b expected %b", obs(), exp_out(0, 1'b0, 1'b1));
        end
    endtask

    task automatic test_directed();
        logic [1:0] ops[5]    = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b00};
        logic [5:0] fns[5]    = '{6'b001000, 6'b011001, 6'b011000, 6'b000000, 6'b000000};
        logic       longs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int         lat[5]    = '{4, 5, 4, 3, 5};
        for (int k = 0; k < 5; k++) begin
            build_seq(ops[k], fns[k], longs[k]);
            n_checks++;
            if (exp_q.size() != lat[k]) begin
                n_fail++;
                $display("FAIL latency_model_%0d: got %0d expected %0d", k, exp_q.size(), lat[k]);
            end
            foreach (exp_q[i]) begin
                drive_inputs(exp_q[i], ops[k], fns[k], longs[k]);
                #1;
                n_checks++;
                if (State !== 4'(exp_q[i])) begin
                    n_fail++;
                    $display("FAIL dir%0d_state_step%0d: got %0d expected %0d", k, i, State, exp_q[i]);
                end
                n_checks++;
                if (obs() !== exp_out(exp_q[i], 1'b0, 1'b1)) begin
                    n_fail++;
                    $display("FAIL dir%0d_outputs_step%0d: got %b expected %b", k, i, obs(), exp_out(exp_q[i], 1'b0, 1'b1));
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_undef_reset();
        build_seq(2'b11, 6'd0, 1'b0);
        build_seq(2'b11, 6'd0, 1'b0);
        foreach (exp_q[i]) begin
            drive_inputs(exp_q[i], 2'b11, 6'd0, 1'b0);
            #1;
            n_checks++;
            if (State !== 4'(exp_q[i]) || obs() !== exp_out(exp_q[i], 1'b0, 1'b1)) begin
                n_fail++;
                $display("FAIL undef_step%0d: state %0d outputs %b expected %0d %b", i, State, obs(), exp_q[i], exp_out(exp_q[i], 1'b0, 1'b1));
            end
            @(negedge clk);
        end
        build_seq(2'b01, 6'b011001, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_inputs(exp_q[i], 2'b01, 6'b011001, 1'b0);
            if (i == 2) reset = 1'b1;
            #1;
            n_checks++;
            if (State !== 4'(exp_q[i])) begin
                n_fail++;
                $display("FAIL ldr_abort_state_step%0d: got %0d expected %0d", i, State, exp_q[i]);
            end
            n_checks++;
            if (obs() !== exp_out(exp_q[i], i == 2, 1'b1)) begin
                n_fail++;
                $display("FAIL ldr_abort_outputs_step%0d: got %b expected %b", i, obs(), exp_out(exp_q[i], i == 2, 1'b1));
            end
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (State !== 4'd0) begin
            n_fail++;
            $display("FAIL after_abort_state: got %0d expected 0", State);
        end
    endtask

    task automatic test_illegal();
        build_seq(2'b10, 6'd0, 1'b0);
        foreach (exp_q[i]) begin
            drive_inputs(exp_q[i], 2'b10, 6'd0, 1'b0);
            #1;
            n_checks++;
            if (State !== 4'(exp_q[i])) begin
                n_fail++;
                $display("FAIL illegal_pre_state_step%0d: got %0d expected %0d", i, State, exp_q[i]);
            end
            if (exp_q[i] != 9) @(negedge clk);
        end
        force dut.state = 4'd12;
        #1;
        n_checks++;
        if (State !== 4'd12 || obs() !== exp_out(12, 1'b0, 1'b1)) begin
            n_fail++;
            $display("FAIL illegal_outputs: state %0d outputs %b expected 12 %b", State, obs(), exp_out(12, 1'b0, 1'b1));
        end
        release dut.state;
        @(negedge clk);
        #1;
        n_checks++;
        if (State !== 4'd0) begin
            n_fail++;
            $display("FAIL illegal_recover: got %0d expected 0", State);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] op;
        logic [5:0] f;
        logic       il;
        for (int k = 0; k < 60; k++) begin
            op = 2'($urandom);
            f  = 6'($urandom);
            il = 1'($urandom);
            build_seq(op, f, il);
            foreach (exp_q[i]) begin
                drive_inputs(exp_q[i], op, f, il);
                #1;
                n_checks++;
                if (State !== 4'(exp_q[i]) || obs() !== exp_out(exp_q[i], 1'b0, 1'b1)) begin
                    n_fail++;
                    $display("FAIL rand%0d_step%0d op=%b f=%b il=%b: state %0d outputs %b expected %0d %b",
                             k, i, op, f, il, State, obs(), exp_q[i], exp_out(exp_q[i], 1'b0, 1'b1));
                end
                @(negedge clk);
            end
        end
    endtask

`ifdef MAINFSM_MEMWAIT_EN
    task automatic test_memwait();
        int st_l[$];
        logic mr_l[$];
        int ir_pulses;
        int w1, w2;
        for (int k = 0; k < 4; k++) begin
            st_l.delete();
            mr_l.delete();
            if (k == 0) begin
                w1 = 3;
                w2 = 2;
            end else begin
                w1 = $urandom_range(0, 4);
                w2 = $urandom_range(0, 4);
            end
            build_seq(2'b01, (k % 2 == 0) ? 6'b011001 : 6'b011000, 1'b0);
            foreach (exp_q[i]) begin
                if (exp_q[i] == 0 || exp_q[i] == 3 || exp_q[i] == 5) begin
                    for (int j = 0; j < ((exp_q[i] == 0) ? w1 : w2); j++) begin
                        st_l.push_back(exp_q[i]);
                        mr_l.push_back(1'b0);
                    end
                end
                st_l.push_back(exp_q[i]);
                mr_l.push_back(1'b1);
            end
            n_checks++;
            if (k == 0 && st_l.size() != 10) begin
                n_fail++;
                $display("FAIL wait_latency: got %0d expected 10", st_l.size());
            end
            ir_pulses = 0;
            foreach (st_l[i]) begin
                MemReady = mr_l[i];
                drive_inputs(st_l[i], 2'b01, (k % 2 == 0) ? 6'b011001 : 6'b011000, 1'b0);
                #1;
                if (IRWrite === 1'b1) ir_pulses++;
                n_checks++;
                if (State !== 4'(st_l[i]) || obs() !== exp_out(st_l[i], 1'b0, mr_l[i])) begin
                    n_fail++;
                    $display("FAIL wait%0d_step%0d: state %0d outputs %b expected %0d %b",
                             k, i, State, obs(), st_l[i], exp_out(st_l[i], 1'b0, mr_l[i]));
                end
                @(negedge clk);
            end
            MemReady = 1'b1;
            n_checks++;
            if (ir_pulses != 1) begin
                n_fail++;
                $display("FAIL wait%0d_irwrite_pulses: got %0d expected 1", k, ir_pulses);
            end
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_undef_reset();
        test_illegal();
        test_back_to_back();
`ifdef MAINFSM_MEMWAIT_EN
        test_memwait();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
